// File: rtl/fft_bitrev_reorder.sv
// rtl/fft_bitrev_reorder.sv - ping-pong reorder buffer, bit-reversed in, natural order out
module fft_bitrev_reorder #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              sync_err
);

    localparam int N = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    // Both banks live in one array; the bank bit is the address MSB.
    logic [DATA_W-1:0] mem [0:2*N-1];

    logic [1:0]        full;
    logic [1:0]        full_next;
    logic              wr_bank;
    logic              rd_bank;
    logic [ADDR_W-1:0] wr_cnt;
    logic [ADDR_W-1:0] rd_cnt;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_fire;
    logic              rd_fire;
    logic              wr_end;
    logic              rd_end;

    assign in_ready  = !full[wr_bank];
    assign out_valid = full[rd_bank];
    assign out_data  = mem[{rd_bank, rd_cnt}];
    assign out_last  = out_valid && (rd_cnt == LAST_IDX);

    assign wr_fire = in_valid && in_ready;
    assign rd_fire = out_valid && out_ready;
    assign wr_end  = (wr_cnt == LAST_IDX);
    assign rd_end  = (rd_cnt == LAST_IDX);

    // Full bit reversal of the write counter gives the natural-order slot.
    always_comb begin
        wr_addr = '0;
        for (int k = 0; k < ADDR_W; k++) begin
            wr_addr[k] = wr_cnt[ADDR_W-1-k];
        end
    end

    // Frame-complete and drain-complete target different banks, so both apply.
    always_comb begin
        full_next = full;
        if (wr_fire && wr_end) begin
            full_next[wr_bank] = 1'b1;
        end
        if (rd_fire && rd_end) begin
            full_next[rd_bank] = 1'b0;
        end
    end

    // Sample storage: no reset, contents are only observed once a bank is full.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[{wr_bank, wr_addr}] <= in_data;
        end
    end

    // Bank pointers, counters, full flags and the frame-sync error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full     <= 2'b00;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            sync_err <= 1'b0;
        end else begin
            full     <= full_next;
            sync_err <= wr_fire && (in_last != wr_end);
            if (wr_fire) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_end) begin
                    wr_bank <= !wr_bank;
                end
            end
            if (rd_fire) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (rd_end) begin
                    rd_bank <= !rd_bank;
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb/tb_fft_bitrev_reorder.sv - self-checking bench for fft_bitrev_reorder
module tb_fft_bitrev_reorder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        sync_err;

    logic        ready_man;
    logic        rnd_en;
    logic        rnd_bit;

    int errors = 0;
    int checks = 0;
    int stalls = 0;
    int rx_cnt = 0;
    int sync_cnt = 0;
    logic mon_en;

    logic [31:0] q_data[$];
    logic        q_last[$];

    int br[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    typedef struct {
        logic [31:0] din;
        logic        lin;
        logic [31:0] exp_data;
        logic        exp_last;
    } vec_t;
    vec_t tv[16];

    assign out_ready = rnd_en ? rnd_bit : ready_man;

    fft_bitrev_reorder #(.ADDR_W(4), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Random consumer readiness, changed just after each rising edge.
    always @(posedge clk) begin
        #1 rnd_bit = 1'($urandom_range(0, 1));
    end

    // Output scoreboard: a transfer seen at the falling edge commits at the next rising edge.
    always @(negedge clk) begin
        if (sync_err) sync_cnt++;
        if (rst_n && mon_en && out_valid && out_ready) begin
            rx_cnt++;
            if (q_data.size() == 0) begin
                chk("unexpected_output", {32'd0, out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                chk("out_data", {32'd0, out_data}, {32'd0, q_data[0]});
                chk("out_last", {63'd0, out_last}, {63'd0, q_last[0]});
                void'(q_data.pop_front());
                void'(q_last.pop_front());
            end
        end
    end

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && n < 2000) begin
            n++;
            @(negedge clk);
        end
        if (n > 0) stalls++;
        if (n >= 2000) chk("put_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_frame(input logic [31:0] base);
        for (int j = 0; j < 16; j++) begin
            q_data.push_back(base + 32'(j));
            q_last.push_back(j == 15);
        end
    endtask

    task automatic send_frame(input logic [31:0] base, input logic [15:0] mask, input logic rnd);
        for (int i = 0; i < 16; i++) begin
            if (rnd) begin
                while ($urandom_range(0, 1) == 1) idle();
            end
            put(base + 32'(br[i]), mask[i]);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q_data.size() > 0 && n < 5000) begin
            n++;
            idle();
        end
        chk("drain_left", 64'(q_data.size()), 64'd0);
    endtask

    initial begin
        int s0;
        int r0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        ready_man = 1'b0; rnd_en = 1'b0; mon_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tv[i].din      = 32'hA000 + 32'(br[i]);
            tv[i].lin      = (i == 15);
            tv[i].exp_data = 32'hA000 + 32'(i);
            tv[i].exp_last = (i == 15);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_last", {63'd0, out_last}, 64'd0);
        chk("rst_sync_err", {63'd0, sync_err}, 64'd0);
        rst_n = 1'b1;
        idle();

        // Natural reorder from the vector table.
        ready_man = 1'b1;
        for (int i = 0; i < 16; i++) begin
            put(tv[i].din, tv[i].lin);
            chk("t1_out_valid_latency", {63'd0, out_valid}, {63'd0, (i == 15)});
        end
        for (int i = 0; i < 16; i++) begin
            chk("t1_valid", {63'd0, out_valid}, 64'd1);
            chk("t1_data", {32'd0, out_data}, {32'd0, tv[i].exp_data});
            chk("t1_last", {63'd0, out_last}, {63'd0, tv[i].exp_last});
            idle();
        end
        chk("t1_empty", {63'd0, out_valid}, 64'd0);

        // Ping-pong streaming: four frames back to back.
        mon_en = 1'b1;
        s0 = stalls;
        r0 = rx_cnt;
        for (int f = 0; f < 4; f++) begin
            expect_frame(32'h1000 * 32'(f + 1));
            send_frame(32'h1000 * 32'(f + 1), 16'h8000, 1'b0);
        end
        wait_drain();
        chk("t2_in_ready_stalls", 64'(stalls - s0), 64'd0);
        chk("t2_rx_count", 64'(rx_cnt - r0), 64'd64);

        // Backpressure: two frames fill both banks.
        ready_man = 1'b0;
        expect_frame(32'h5000);
        send_frame(32'h5000, 16'h8000, 1'b0);
        expect_frame(32'h6000);
        send_frame(32'h6000, 16'h8000, 1'b0);
        in_valid = 1'b1;
        in_data = 32'hDEAD;
        for (int k = 0; k < 4; k++) begin
            chk("t3_in_ready_full", {63'd0, in_ready}, 64'd0);
            chk("t3_hold_data", {32'd0, out_data}, 64'h5000);
            chk("t3_hold_valid", {63'd0, out_valid}, 64'd1);
            idle();
        end
        in_valid = 1'b0;
        ready_man = 1'b1;
        idle();
        ready_man = 1'b0;
        chk("t3_after_pulse", {32'd0, out_data}, 64'h5001);
        chk("t3_ready_after_pulse", {63'd0, in_ready}, 64'd0);
        idle();
        chk("t3_after_pulse_hold", {32'd0, out_data}, 64'h5001);
        ready_man = 1'b1;
        for (int k = 1; k < 16; k++) begin
            chk("t3_in_ready_low", {63'd0, in_ready}, 64'd0);
            idle();
        end
        chk("t3_in_ready_rise", {63'd0, in_ready}, 64'd1);
        wait_drain();

        // Random stalls on both sides over 20 frames.
        r0 = rx_cnt;
        rnd_en = 1'b1;
        for (int f = 0; f < 20; f++) begin
            expect_frame(32'h10000 * 32'(f + 1));
            send_frame(32'h10000 * 32'(f + 1), 16'h8000, 1'b1);
        end
        wait_drain();
        rnd_en = 1'b0;
        chk("t4_rx_count", 64'(rx_cnt - r0), 64'd320);
        chk("t4_no_sync_err", 64'(sync_cnt), 64'd0);

        // Frame sync errors.
        s0 = sync_cnt;
        expect_frame(32'h7000);
        send_frame(32'h7000, 16'h8080, 1'b0);
        wait_drain();
        chk("t5_early_last", 64'(sync_cnt - s0), 64'd1);
        s0 = sync_cnt;
        expect_frame(32'h7100);
        send_frame(32'h7100, 16'h0000, 1'b0);
        wait_drain();
        chk("t5_missing_last", 64'(sync_cnt - s0), 64'd1);

        // Reset mid-operation while frame 0 drains.
        ready_man = 1'b0;
        expect_frame(32'h8000);
        send_frame(32'h8000, 16'h8000, 1'b0);
        ready_man = 1'b1;
        for (int i = 0; i < 10; i++) put(32'h9000 + 32'(br[i]), 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("t6_rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("t6_rst_out_last", {63'd0, out_last}, 64'd0);
        q_data.delete();
        q_last.delete();
        idle();
        idle();
        rst_n = 1'b1;
        idle();
        r0 = rx_cnt;
        expect_frame(32'hB000);
        send_frame(32'hB000, 16'h8000, 1'b0);
        wait_drain();
        chk("t6_rx_count", 64'(rx_cnt - r0), 64'd16);
        idle();
        chk("t6_idle_valid", {63'd0, out_valid}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
